// File: rtl/montgomery_pkg.sv
// Shared types for the Montgomery shift-reducer arbiter: per-requester
// modulus configuration record, arbiter FSM states and a clog2 helper.
package montgomery_pkg;

  // Default field widths of the configuration record.
  localparam int MONT_QH_W = 32;
  localparam int MONT_K_W  = 5;

  typedef struct packed {
    logic [MONT_QH_W-1:0] qH;
    logic [MONT_K_W-1:0]  K1;
    logic [MONT_K_W-1:0]  K2;
    logic [MONT_K_W-1:0]  K3;
  } mont_cfg_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_t;

  // clog2 that never returns 0, so index fields are at least one bit wide.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/montgomery_shift_arbiter_rr_arbiter.sv
// Round-robin picker: grants the first eligible index strictly after ptr,
// wrapping modulo N. Pure combinational.
module rr_arbiter
  import montgomery_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_safe(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  int idx;

  // Scan from farthest to nearest so the nearest eligible index wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (eligible[idx]) begin
        grant     = N'(1) << idx;
        grant_idx = IW'(idx);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/montgomery_shift_arbiter.sv
// Shares one fixed-latency Montgomery shift reducer among NREQ requesters.
// Round-robin issue, a valid/ID delay line matched to the reducer latency,
// and a RUN/DRAIN/WRITE FSM that quiesces the pipe before a config write.
// Optional: define MONTGOMERY_SHIFT_ARBITER_PERF_EN for per-requester
// 32-bit handshake counters on perf_cnt.
module montgomery_shift_arbiter
  import montgomery_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int LOGQ  = 64,
  parameter int LOGQH = MONT_QH_W,
  parameter int LOGK1 = MONT_K_W,
  parameter int LOGK2 = MONT_K_W,
  parameter int LOGK3 = MONT_K_W,
  parameter int LAT   = 8,
  localparam int IDW  = clog2_safe(NREQ),
  localparam int CNTW = clog2_safe(LAT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*2*LOGQ-1:0] req_C,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [LOGQ-1:0]        rsp_T,
  input  logic                   cfg_req,
  input  logic [IDW-1:0]         cfg_sel,
  input  logic [LOGQH-1:0]       cfg_qH,
  input  logic [LOGK1-1:0]       cfg_K1,
  input  logic [LOGK2-1:0]       cfg_K2,
  input  logic [LOGK3-1:0]       cfg_K3,
  output logic                   cfg_ack,
  output logic [2*LOGQ-1:0]      red_C,
  output logic [LOGQH-1:0]       red_qH,
  output logic [LOGK1-1:0]       red_K1,
  output logic [LOGK2-1:0]       red_K2,
  output logic [LOGK3-1:0]       red_K3,
`ifdef MONTGOMERY_SHIFT_ARBITER_PERF_EN
  output logic [NREQ*32-1:0]     perf_cnt,
`endif
  input  logic [LOGQ-1:0]        red_T
);

  arb_state_t              state, state_nx;
  logic [NREQ-1:0]         cfg_loaded;
  mont_cfg_t               cfg_mem [NREQ];
  mont_cfg_t               cur_cfg;
  logic [IDW-1:0]          rr_ptr;
  logic [NREQ-1:0]         eligible, grant;
  logic [IDW-1:0]          grant_idx;
  logic                    grant_vld;
  logic                    issue_en, hs;
  logic [2*LOGQ-1:0]       c_arr [NREQ];
  logic [LAT-1:0]          vld_pipe;
  logic [LAT-1:0][IDW-1:0] id_pipe;
  logic [CNTW-1:0]         inflight;

  // Unflatten operand bus into per-requester slices.
  for (genvar i = 0; i < NREQ; i++) begin : g_c
    assign c_arr[i] = req_C[i*2*LOGQ +: 2*LOGQ];
  end

  assign eligible = req_valid & cfg_loaded;

  rr_arbiter #(.N(NREQ)) u_rr (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // A pending cfg_req blocks issue in the same cycle it appears.
  assign issue_en  = (state == ST_RUN) && !cfg_req;
  assign req_ready = issue_en ? grant : '0;
  assign hs        = issue_en && grant_vld;

  // Reducer operand/config mux; zeros when nothing issues.
  always_comb begin
    red_C   = '0;
    cur_cfg = '0;
    if (hs) begin
      red_C   = c_arr[grant_idx];
      cur_cfg = cfg_mem[grant_idx];
    end
  end

  assign red_qH = LOGQH'(cur_cfg.qH);
  assign red_K1 = LOGK1'(cur_cfg.K1);
  assign red_K2 = LOGK2'(cur_cfg.K2);
  assign red_K3 = LOGK3'(cur_cfg.K3);

  // Count requests still inside the reducer.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < LAT; k++) inflight = inflight + CNTW'(vld_pipe[k]);
  end

  // Next-state logic; cfg_ack is high for the single WRITE cycle.
  always_comb begin
    state_nx = state;
    cfg_ack  = 1'b0;
    case (state)
      ST_RUN:   if (cfg_req) state_nx = ST_DRAIN;
      ST_DRAIN: if (inflight == '0) state_nx = ST_WRITE;
      ST_WRITE: begin
        cfg_ack  = 1'b1;
        state_nx = ST_RUN;
      end
      default:  state_nx = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nx;
  end

  // Config payload store; only valid once the matching loaded bit is set.
  always_ff @(posedge clk) begin
    if (state == ST_WRITE)
      cfg_mem[cfg_sel] <= '{qH: MONT_QH_W'(cfg_qH), K1: MONT_K_W'(cfg_K1),
                            K2: MONT_K_W'(cfg_K2),  K3: MONT_K_W'(cfg_K3)};
  end

  // Loaded flags and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_loaded <= '0;
      rr_ptr     <= IDW'(NREQ - 1);
    end else begin
      if (state == ST_WRITE) cfg_loaded[cfg_sel] <= 1'b1;
      if (hs)                rr_ptr <= grant_idx;
    end
  end

  // Valid/ID delay line, shifting every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= hs;
      id_pipe[0]  <= grant_idx;
      for (int k = 1; k < LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        id_pipe[k]  <= id_pipe[k-1];
      end
    end
  end

  // Register reducer output alongside the tag leaving the delay line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_T     <= '0;
    end else if (vld_pipe[LAT-1]) begin
      rsp_valid <= NREQ'(1) << id_pipe[LAT-1];
      rsp_id    <= id_pipe[LAT-1];
      rsp_T     <= red_T;
    end else begin
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_T     <= '0;
    end
  end

`ifdef MONTGOMERY_SHIFT_ARBITER_PERF_EN
  logic [NREQ-1:0] hs_vec;
  assign hs_vec = req_valid & req_ready;

  for (genvar i = 0; i < NREQ; i++) begin : g_perf
    logic [31:0] cnt_q;
    // Wrapping handshake counter for requester i.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)           cnt_q <= '0;
      else if (hs_vec[i]) cnt_q <= cnt_q + 32'd1;
    end
    assign perf_cnt[i*32 +: 32] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_montgomery_shift_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed responses, a monitor pops
// and compares on each rsp_valid. The reducer stand-in returns C >> LOGQ
// after LAT cycles, which equals C*2^-64 mod Q for C = x*2^64 with x < Q.
module tb_montgomery_shift_arbiter;
  localparam int NREQ = 4, LOGQ = 64, LOGQH = 32, LAT = 8, IDW = 2;
  localparam logic [31:0] QH = 32'h800F_F001;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req_valid = '0, req_ready;
  logic [NREQ*2*LOGQ-1:0] req_C = '0;
  logic [NREQ-1:0]        rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [LOGQ-1:0]        rsp_T;
  logic                   cfg_req = 1'b0, cfg_ack;
  logic [IDW-1:0]         cfg_sel = '0;
  logic [LOGQH-1:0]       cfg_qH = '0;
  logic [4:0]             cfg_K1 = '0, cfg_K2 = '0, cfg_K3 = '0;
  logic [2*LOGQ-1:0]      red_C;
  logic [LOGQH-1:0]       red_qH;
  logic [4:0]             red_K1, red_K2, red_K3;
  logic [LOGQ-1:0]        red_T;
`ifdef MONTGOMERY_SHIFT_ARBITER_PERF_EN
  logic [NREQ*32-1:0]     perf_cnt;
`endif

  montgomery_shift_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_C(req_C), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_T(rsp_T),
    .cfg_req(cfg_req), .cfg_sel(cfg_sel), .cfg_qH(cfg_qH), .cfg_K1(cfg_K1),
    .cfg_K2(cfg_K2), .cfg_K3(cfg_K3), .cfg_ack(cfg_ack), .red_C(red_C),
    .red_qH(red_qH), .red_K1(red_K1), .red_K2(red_K2), .red_K3(red_K3),
`ifdef MONTGOMERY_SHIFT_ARBITER_PERF_EN
    .perf_cnt(perf_cnt),
`endif
    .red_T(red_T)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reducer stand-in: LAT-cycle pipe of the operand's upper half.
  logic [LOGQ-1:0] rpipe [LAT];
  always @(posedge clk) begin
    rpipe[0] <= red_C[2*LOGQ-1:LOGQ];
    for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign red_T = rpipe[LAT-1];

  typedef struct { int id; logic [63:0] t; int due; } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  logic [31:0] tb_qh [NREQ];
  logic [4:0]  tb_k1 [NREQ];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got valid=%b id=%0d T=%0h expected none", rsp_valid, rsp_id, rsp_T);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_valid", 128'(rsp_valid), 128'(4'b0001 << e.id));
        chk("rsp_id",    128'(rsp_id),    128'(e.id));
        chk("rsp_T",     128'(rsp_T),     128'(e.t));
        chk("rsp_cycle", 128'(cyc),       128'(e.due));
      end
    end
  end

  task automatic set_c(input int sel, input logic [63:0] x);
    req_C[sel*128 +: 128] = {x, 64'h0};
  endtask

  task automatic push_exp(input int sel, input logic [63:0] x);
    exp_t e;
    e.id = sel; e.t = x; e.due = cyc + LAT + 1;
    sb.push_back(e);
  endtask

  // Raise cfg_req, wait for the ack, drop it and confirm a single-cycle pulse.
  task automatic program_cfg(input int sel, input logic [31:0] qh, input logic [4:0] k1,
                             input logic [4:0] k2, input logic [4:0] k3, output int ack_cyc);
    int n;
    @(posedge clk); #1;
    cfg_sel = IDW'(sel); cfg_qH = qh; cfg_K1 = k1; cfg_K2 = k2; cfg_K3 = k3;
    cfg_req = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cfg_ack && n < 60) begin @(negedge clk); n++; end
    ack_cyc = cyc;
    chk("cfg_ack_seen", 128'(cfg_ack), 128'(1));
    @(posedge clk); #1;
    cfg_req = 1'b0;
    tb_qh[sel] = qh; tb_k1[sel] = k1;
    @(negedge clk);
    chk("cfg_ack_pulse", 128'(cfg_ack), 128'(0));
  endtask

  task automatic wait_idle(input int ncyc);
    repeat (ncyc) @(negedge clk);
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
  endtask

  task automatic hard_reset();
    @(negedge clk); #2;
    rst = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int ack_cyc, last_issue, n;
    // Reset values
    #1 rst = 1'b0;
    #1;
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_id",    128'(rsp_id),    128'(0));
    chk("rst_rsp_T",     128'(rsp_T),     128'(0));
    chk("rst_cfg_ack",   128'(cfg_ack),   128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Unconfigured slot 2 requesting: never granted.
    @(posedge clk); #1;
    req_valid = 4'b0100; set_c(2, 64'h22);
    repeat (20) begin
      @(negedge clk);
      chk("unconfigured_ready", 128'(req_ready), 128'(0));
    end
    @(posedge clk); #1 req_valid = '0;

    // Slot 0 with the common modulus config; single request C = 5*2^64.
    program_cfg(0, QH, 5'd20, 5'd12, 5'd0, ack_cyc);
    @(posedge clk); #1;
    req_valid = 4'b0001; set_c(0, 64'd5);
    n = 0;
    @(negedge clk);
    while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
    chk("s1_ready",  128'(req_ready),  128'(4'b0001));
    chk("s1_red_C",  128'(red_C),      {64'd5, 64'h0});
    chk("s1_red_qH", 128'(red_qH),     128'(QH));
    chk("s1_red_K",  128'({red_K1, red_K2, red_K3}), 128'({5'd20, 5'd12, 5'd0}));
    push_exp(0, 64'd5);
    @(posedge clk); #1 req_valid = '0;
    wait_idle(LAT + 3);

    // All four slots configured and continuously valid: strict RR order.
    hard_reset();
    for (int s = 0; s < NREQ; s++) program_cfg(s, QH, 5'd20, 5'd12, 5'd0, ack_cyc);
    @(posedge clk); #1;
    for (int s = 0; s < NREQ; s++) set_c(s, 64'h100 + 64'(s));
    req_valid = 4'b1111;
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      chk("s2_grant", 128'(req_ready), 128'(4'b0001 << (r % 4)));
      push_exp(r % 4, 64'h100 * 64'(r / 4 + 1) + 64'(r % 4));
      @(posedge clk); #1;
      set_c(r % 4, 64'h100 * 64'(r / 4 + 2) + 64'(r % 4));
    end
    req_valid = '0;
    wait_idle(LAT + 3);
`ifdef MONTGOMERY_SHIFT_ARBITER_PERF_EN
    for (int s = 0; s < NREQ; s++) chk("perf_cnt", 128'(perf_cnt[s*32 +: 32]), 128'(2));
`endif

    // Back-to-back from slot 1, then reconfigure slot 3 while it drains.
    @(posedge clk); #1;
    req_valid = 4'b0010; set_c(1, 64'h501);
    last_issue = 0;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk("s4_b2b_ready", 128'(req_ready), 128'(4'b0010));
      push_exp(1, 64'h501 + 64'(r));
      last_issue = cyc;
      @(posedge clk); #1;
      set_c(1, 64'h502 + 64'(r));
    end
    cfg_sel = 2'd3; cfg_qH = 32'h7FFF_0001; cfg_K1 = 5'd16; cfg_K2 = 5'd8; cfg_K3 = 5'd1;
    cfg_req = 1'b1;
    @(negedge clk);
    chk("s4_ready_drop", 128'(req_ready), 128'(0));
    n = 0;
    while (!cfg_ack && n < 40) begin @(negedge clk); n++; end
    chk("s4_ack_seen",  128'(cfg_ack), 128'(1));
    chk("s4_ack_cycle", 128'(cyc),     128'(last_issue + LAT + 2));
    chk("s4_drained",   128'(sb.size()), 128'(0));
    @(posedge clk); #1;
    cfg_req = 1'b0;
    tb_qh[3] = 32'h7FFF_0001; tb_k1[3] = 5'd16;
    req_valid = 4'b1010; set_c(3, 64'h777);
    @(negedge clk);
    chk("s4_slot3_grant", 128'(req_ready), 128'(4'b1000));
    chk("s4_slot3_qH",    128'(red_qH),    128'(tb_qh[3]));
    chk("s4_slot3_K1",    128'(red_K1),    128'(tb_k1[3]));
    chk("s4_ack_low",     128'(cfg_ack),   128'(0));
    push_exp(3, 64'h777);
    @(posedge clk); #1;
    req_valid = 4'b0010;
    @(negedge clk);
    chk("s4_slot1_resume", 128'(req_ready), 128'(4'b0010));
    push_exp(1, 64'h505);
    @(posedge clk); #1 req_valid = '0;
    wait_idle(LAT + 3);

    // Reset with requests in flight: results are dropped, config cleared.
    @(posedge clk); #1;
    req_valid = 4'b0001;
    for (int r = 0; r < 6; r++) begin
      set_c(0, 64'h900 + 64'(r));
      @(negedge clk);
      chk("s5_issue", 128'(req_ready), 128'(4'b0001));
      push_exp(0, 64'h900 + 64'(r));
      @(posedge clk); #1;
    end
    req_valid = '0;
    n = 0;
    @(negedge clk);
    while (rsp_valid == '0 && n < 20) begin @(negedge clk); n++; end
    chk("s5_first_rsp", 128'(rsp_valid), 128'(4'b0001));
    #2 rst = 1'b0;
    #1;
    chk("s5_async_valid", 128'(rsp_valid), 128'(0));
    chk("s5_async_T",     128'(rsp_T),     128'(0));
    chk("s5_async_id",    128'(rsp_id),    128'(0));
    chk("s5_async_ready", 128'(req_ready), 128'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b1111;
    repeat (LAT + 4) begin
      @(negedge clk);
      chk("s5_unconfigured", 128'(req_ready), 128'(0));
    end
    req_valid = '0;
    wait_idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global bound so a stuck run still reports.
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
